// File: rtl/tone_detect.sv
// tone_detect: decodes a square-wave tone into a note code via half-period matching
module tone_detect #(
  parameter int TOL = 8,
  parameter int MATCH = 3,
  parameter int TIMEOUT = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tone_in,
  output logic [3:0] note,
  output logic       changed,
  output logic       miss
);
  localparam int RW = $clog2(MATCH + 1);
  localparam logic [RW-1:0] RMAX = RW'(MATCH);
  typedef enum logic {IDLE, MEASURE} state_t;
  state_t state, state_nx;
  logic s1, s2, prev, edg, hit, tmo, changed_nx, miss_nx;
  logic [11:0] cnt;
  logic [3:0] cand, cand_nx, note_nx, code;
  logic [RW-1:0] run, run_nx;
  function automatic logic [12:0] half_of(input logic [3:0] c);
    logic [12:0] d;
    d = c[2:0] == 3'd1 ? 13'd947 :
        c[2:0] == 3'd2 ? 13'd842 :
        c[2:0] == 3'd3 ? 13'd758 :
        c[2:0] == 3'd4 ? 13'd710 :
        c[2:0] == 3'd5 ? 13'd631 :
        c[2:0] == 3'd6 ? 13'd568 :
        c[2:0] == 3'd7 ? 13'd505 : 13'd0;
    return c[3] ? d : d << 1;
  endfunction
  function automatic logic near(input logic [11:0] p, input logic [12:0] h);
    logic [12:0] q;
    q = {1'b0, p};
    return (q >= h ? q - h : h - q) <= 13'(TOL);
  endfunction
  assign edg = s2 != prev;
  assign tmo = cnt == 12'(TIMEOUT - 1);
  // find the single code whose half-period lies within tolerance of the measured count
  always_comb begin
    hit = 1'b0;
    code = 4'd0;
    for (int i = 1; i < 16; i++)
      if (i % 8 != 0 && near(cnt, half_of(4'(i)))) begin
        hit = 1'b1;
        code = 4'(i);
      end
  end
  // next-state: start on first edge, classify later edges, fall silent on timeout
  always_comb begin
    state_nx = state;
    cand_nx = cand;
    run_nx = run;
    note_nx = note;
    changed_nx = 1'b0;
    miss_nx = 1'b0;
    if (state == IDLE) begin
      state_nx = edg ? MEASURE : IDLE;
    end else if (edg) begin
      miss_nx = !hit;
      cand_nx = hit ? code : cand;
      run_nx = !hit ? '0 : code != cand ? RW'(1) : run == RMAX ? run : run + 1'b1;
      if (hit && run_nx == RMAX && cand_nx != note) begin
        note_nx = cand_nx;
        changed_nx = 1'b1;
      end
    end else if (tmo) begin
      state_nx = IDLE;
      cand_nx = 4'd0;
      run_nx = '0;
      note_nx = 4'd0;
      changed_nx = note != 4'd0;
    end
  end
  // synchronizer, period counter and decoder state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      prev <= 1'b0;
      cnt <= 12'd0;
      state <= IDLE;
      cand <= 4'd0;
      run <= '0;
      note <= 4'd0;
      changed <= 1'b0;
      miss <= 1'b0;
    end else begin
      s1 <= tone_in;
      s2 <= s1;
      prev <= s2;
      cnt <= edg ? 12'd1 : cnt == 12'hfff ? cnt : cnt + 12'd1;
      state <= state_nx;
      cand <= cand_nx;
      run <= run_nx;
      note <= note_nx;
      changed <= changed_nx;
      miss <= miss_nx;
    end
  end
endmodule

// File: tb/tb_tone_detect.sv
// tb_tone_detect: randomized scoreboard bench for tone_detect against a half-period reference model
module tb_tone_detect;
  localparam int TOL = 8;
  localparam int MATCH = 3;
  localparam int TIMEOUT = 4000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tone_in = 1'b0;
  logic [3:0] note;
  logic changed, miss;
  tone_detect #(.TOL(TOL), .MATCH(MATCH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .tone_in(tone_in), .note(note), .changed(changed), .miss(miss)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int at; bit is_miss; logic [3:0] nt;} ev_t;
  ev_t q[$];
  ev_t mon_e;
  int total = 0;
  int passed = 0;
  int hhi[8] = '{0, 947, 842, 758, 710, 631, 568, 505};
  int hlo[8] = '{0, 1894, 1684, 1516, 1420, 1262, 1136, 1010};
  bit m_meas = 0;
  int m_last = 0;
  int m_cand = 0;
  int m_run = 0;
  logic [3:0] m_note = 4'd0;
  bit lvl = 0;
  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask
  function automatic int classify(int p);
    for (int c = 1; c < 16; c++) begin
      int h;
      if (c % 8 == 0) continue;
      h = c >= 8 ? hhi[c-8] : hlo[c];
      if (p - h <= TOL && h - p <= TOL) return c;
    end
    return 0;
  endfunction
  function automatic int hp(int c);
    return c >= 8 ? hhi[c-8] : hlo[c];
  endfunction
  task automatic push(int at, bit m, logic [3:0] n);
    ev_t e;
    e.at = at;
    e.is_miss = m;
    e.nt = n;
    q.push_back(e);
  endtask
  task automatic model_timeout();
    if (m_note != 4'd0) push(m_last + TIMEOUT + 2, 1'b0, 4'd0);
    m_note = 4'd0;
    m_cand = 0;
    m_run = 0;
    m_meas = 0;
  endtask
  task automatic model_edge(int n);
    int gap, c;
    if (m_meas && n - m_last >= TIMEOUT) model_timeout();
    if (!m_meas) begin
      m_meas = 1;
      m_last = n;
      return;
    end
    gap = n - m_last;
    m_last = n;
    c = classify(gap);
    if (c == 0) begin
      m_run = 0;
      push(n + 3, 1'b1, m_note);
    end else begin
      if (c == m_cand) m_run = m_run < MATCH ? m_run + 1 : MATCH;
      else begin
        m_cand = c;
        m_run = 1;
      end
      if (m_run == MATCH && 4'(m_cand) != m_note) begin
        m_note = 4'(m_cand);
        push(n + 3, 1'b0, m_note);
      end
    end
  endtask
  task automatic half(int d);
    model_edge(cyc + d);
    repeat (d) @(posedge clk);
    #1;
    lvl = ~lvl;
    tone_in = lvl;
  endtask
  task automatic silence(int d);
    if (m_meas && m_last + TIMEOUT + 2 <= cyc + d) model_timeout();
    repeat (d) @(posedge clk);
    #1;
  endtask
  task automatic check_note(string nm);
    logic [3:0] exp;
    exp = m_note;
    fork
      begin
        repeat (5) @(negedge clk);
        chk(nm, int'(note), int'(exp));
      end
    join_none
  endtask
  task automatic reps(int d, int k);
    for (int j = 0; j < k; j++) half(d);
  endtask
  task automatic rst_pulse(bit level);
    repeat (5) @(posedge clk);
    #3;
    chk("events_pending_at_reset", q.size(), 0);
    rst = 1'b1;
    lvl = level;
    tone_in = level;
    #1;
    chk("reset_note", int'(note), 0);
    chk("reset_changed", int'(changed), 0);
    chk("reset_miss", int'(miss), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_meas = 0;
    m_cand = 0;
    m_run = 0;
    m_note = 4'd0;
    if (level) model_edge(cyc);
  endtask
  // scoreboard monitor: every strobe must match the oldest expected event
  always @(negedge clk) begin
    if (!rst && (changed || miss)) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_strobe: got changed=%0b miss=%0b note=%0d required none (cycle %0d)", changed, miss, note, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("strobe_kind", int'({changed, miss}), mon_e.is_miss ? 1 : 2);
        chk("strobe_cycle", cyc, mon_e.at);
        chk("strobe_note", int'(note), int'(mon_e.nt));
      end
    end
  end
  initial begin
    #12;
    chk("reset_note", int'(note), 0);
    chk("reset_changed", int'(changed), 0);
    chk("reset_miss", int'(miss), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    half(20);
    reps(947, 4);
    check_note("lock_947");
    reps(1894, 3);
    check_note("lock_1894");
    reps(842, 2);
    check_note("hold_before_842_lock");
    half(842);
    check_note("lock_842");
    half(938);
    half(956);
    half(938);
    half(956);
    check_note("no_lock_on_misses");
    half(939);
    half(955);
    half(939);
    check_note("lock_tolerance_edges");
    reps(631, 3);
    check_note("lock_631");
    half(947);
    half(947);
    half(1000);
    half(947);
    half(947);
    check_note("no_lock_after_restart");
    half(947);
    check_note("lock_after_restart");
    reps(631, 3);
    silence(TIMEOUT + 100);
    check_note("timeout_silence");
    half(20);
    reps(631, 3);
    half(TIMEOUT - 1);
    check_note("edge_on_timeout_cycle");
    silence(TIMEOUT + 100);
    half(20);
    reps(505, 3);
    check_note("lock_505");
    rst_pulse(1'b1);
    reps(505, 2);
    check_note("no_relock_yet");
    half(505);
    check_note("relock_505");
    for (int g = 0; g < 6; g++) begin
      int c, k;
      c = $urandom_range(1, 15);
      if (c == 8) c = 9;
      k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++)
        half(hp(c) + int'($urandom_range(0, 2 * TOL + 6)) - (TOL + 3));
      check_note("random_group");
    end
    silence(TIMEOUT + 100);
    for (int i = 0; i < 5000 && q.size() != 0; i++) @(posedge clk);
    repeat (8) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
